s2p_deframer: RTL and testbench

//  Serial-to-parallel stage that sits directly downstream of the P2S serializer.
//  - Samples ser_in on every clk edge where ser_en=1; input is MSB-first.
//  - A frame is one contiguous run of ser_en=1. Each frame is packed into a

---
 rtl/s2p_deframer_pkg.sv | 18 +
 rtl/s2p_out_fifo.sv | 48 ++++
 rtl/s2p_deframer.sv | 113 +++++++++++
 tb/tb_s2p_deframer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/s2p_deframer_pkg.sv
// Shared types and defaults for the serial-to-parallel deframer.
// Holds the FSM state encoding, the length-width helper and the default match settings.
package s2p_deframer_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StShift
  } state_e;

  localparam logic [7:0]  DefMatchPattern = 8'hAA;
  localparam int unsigned DefMatchLen     = 7;

  // Bits needed to hold a count of 0..data_w.
  function automatic int unsigned len_width(int unsigned data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/s2p_out_fifo.sv
// Two-entry valid/ready output buffer for completed frames.
// A push while full is dropped unless a pop happens in the same cycle.
module s2p_out_fifo #(
  parameter int unsigned WIDTH = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             overflow
);

  logic [WIDTH-1:0] mem_q [2];
  logic             rd_ptr_q, wr_ptr_q;
  logic [1:0]       count_q;
  logic             full, pop, accept;

  assign full      = (count_q == 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign pop       = out_valid && out_ready;
  // The pop frees its slot in the same cycle, so a push while full is still legal then.
  assign accept    = push && (!full || pop);
  assign overflow  = push && full && !pop;
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (accept) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, accept} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/s2p_deframer.sv
// Serial-to-parallel deframer: packs each contiguous ser_en run (MSB first) into a
// left-aligned word with its bit count and a pattern-match flag, buffered two deep.
module s2p_deframer
  import s2p_deframer_pkg::*;
#(
  parameter int unsigned        DATA_W        = 8,
  parameter logic [DATA_W-1:0]  MATCH_PATTERN = DATA_W'(DefMatchPattern),
  parameter int unsigned        MATCH_LEN     = DefMatchLen,
  localparam int unsigned       LEN_W         = len_width(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ser_en,
  input  logic              ser_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [LEN_W-1:0]  out_len,
  output logic              out_match,
  output logic              ovf_sticky,
  input  logic              ovf_clr
);

  localparam int unsigned EntryW = DATA_W + LEN_W + 1;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shifted;
  logic [LEN_W-1:0]  cnt_q, next_cnt;
  logic              full_frame;
  logic              close;
  logic [DATA_W-1:0] close_word;
  logic [LEN_W-1:0]  close_len;
  logic              close_match;
  logic              fifo_overflow;
  logic [EntryW-1:0] fifo_data;

  // A bit sampled in idle starts a fresh frame; in shift it appends at the LSB.
  assign shifted    = (state_q == StIdle) ? DATA_W'(ser_in) : ((shreg_q << 1) | DATA_W'(ser_in));
  assign next_cnt   = (state_q == StIdle) ? LEN_W'(1) : (cnt_q + 1'b1);
  assign full_frame = ser_en && (next_cnt == LEN_W'(DATA_W));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (ser_en && !full_frame) state_d = StShift;
      StShift: if (!ser_en || full_frame) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    close      = 1'b0;
    close_word = '0;
    close_len  = '0;
    if (full_frame) begin
      close      = 1'b1;
      close_word = shifted;
      close_len  = LEN_W'(DATA_W);
    end else if (!ser_en && (state_q == StShift)) begin
      close      = 1'b1;
      close_word = shreg_q << (LEN_W'(DATA_W) - cnt_q);
      close_len  = cnt_q;
    end
    close_match = close && (close_len == LEN_W'(MATCH_LEN)) && (close_word == MATCH_PATTERN);
  end

  // Count returns to 0 on every close so a full-frame wrap never yields an empty frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else if (ser_en) begin
      shreg_q <= shifted;
      cnt_q   <= full_frame ? '0 : next_cnt;
    end else begin
      cnt_q   <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_sticky <= 1'b0;
    end else if (fifo_overflow) begin
      ovf_sticky <= 1'b1;
    end else if (ovf_clr) begin
      ovf_sticky <= 1'b0;
    end
  end

  s2p_out_fifo #(
    .WIDTH (EntryW)
  ) u_out_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (close),
    .push_data ({close_word, close_len, close_match}),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (fifo_data),
    .overflow  (fifo_overflow)
  );

  assign {out_data, out_len, out_match} = fifo_data;

endmodule

// File: tb/tb_s2p_deframer.sv
// Bench for s2p_deframer: directed scenarios plus random traffic against a frame-level model.
module tb_s2p_deframer;

  logic       clk = 1'b0;
  logic       rst, ser_en, ser_in, out_ready, ovf_clr;
  logic       out_valid, out_match, ovf_sticky;
  logic [7:0] out_data;
  logic [3:0] out_len;

  s2p_deframer dut (
    .clk        (clk),
    .rst        (rst),
    .ser_en     (ser_en),
    .ser_in     (ser_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_len    (out_len),
    .out_match  (out_match),
    .ovf_sticky (ovf_sticky),
    .ovf_clr    (ovf_clr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] w;
    logic [3:0] n;
    logic       m;
  } ent_t;

  ent_t        mq[$];
  ent_t        got[$];
  int unsigned f_val, f_n;
  logic        m_ovf;
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic ent_t make_ent(input int unsigned v, input int unsigned n);
    ent_t e;
    e.w = 8'((v << (8 - n)) & 32'hFF);
    e.n = 4'(n);
    e.m = (n == 7) && (e.w == 8'hAA);
    return e;
  endfunction

  task automatic model_reset();
    mq.delete();
    f_val = 0;
    f_n   = 0;
    m_ovf = 1'b0;
  endtask

  // Frame-level reference: accumulate bits, close on gap or on the 8th bit, 2-deep queue.
  task automatic model_edge(input logic en, input logic b, input logic rdy, input logic clr);
    bit   have = 0;
    bit   drop = 0;
    bit   pop;
    ent_t e;
    pop = (mq.size() > 0) && rdy;
    if (en) begin
      f_val = (f_val << 1) | int'(b);
      f_n++;
      if (f_n == 8) begin
        e = make_ent(f_val, 8); have = 1; f_val = 0; f_n = 0;
      end
    end else if (f_n > 0) begin
      e = make_ent(f_val, f_n); have = 1; f_val = 0; f_n = 0;
    end
    if (pop) void'(mq.pop_front());
    if (have) begin
      if (mq.size() < 2) mq.push_back(e);
      else drop = 1;
    end
    if (drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
  endtask

  task automatic check_outputs();
    ent_t h;
    h = (mq.size() > 0) ? mq[0] : '0;
    check("out_valid", 32'(out_valid), 32'(mq.size() > 0));
    check("out_data", 32'(out_data), 32'(h.w));
    check("out_len", 32'(out_len), 32'(h.n));
    check("out_match", 32'(out_match), 32'(h.m));
    check("ovf_sticky", 32'(ovf_sticky), 32'(m_ovf));
  endtask

  task automatic step(input logic en, input logic b, input logic rdy, input logic clr);
    @(negedge clk);
    ser_en = en; ser_in = b; out_ready = rdy; ovf_clr = clr;
    check_outputs();
    if (out_valid && rdy) got.push_back({out_data, out_len, out_match});
    @(posedge clk);
    model_edge(en, b, rdy, clr);
  endtask

  task automatic send_bits(input logic [15:0] v, input int n, input logic rdy);
    for (int i = n - 1; i >= 0; i--) step(1'b1, v[i], rdy, 1'b0);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, rdy, 1'b0);
  endtask

  task automatic check_got(input string tag, input int idx, input ent_t exp);
    check(tag, (got.size() > idx) ? 32'(got[idx]) : 32'hFFFF_FFFF, 32'(exp));
  endtask

  task automatic check_zero_outputs(input string tag);
    check(tag, {out_valid, out_data, out_len, out_match, ovf_sticky}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; ser_en = 1'b0; ser_in = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
    model_reset();
    #12;
    check_zero_outputs("reset_outputs");
    @(negedge clk);
    rst = 1'b0;

    // Alternating 7-bit pattern matches and is presented for one cycle.
    got.delete();
    send_bits(16'h0055, 7, 1'b1);
    idle(4, 1'b1);
    check("t1_count", 32'(got.size()), 32'd1);
    check_got("t1_frame", 0, '{w: 8'hAA, n: 4'd7, m: 1'b1});

    // 16 contiguous bits split into two full frames, no empty third.
    got.delete();
    send_bits(16'hC35A, 16, 1'b1);
    idle(4, 1'b1);
    check("t2_count", 32'(got.size()), 32'd2);
    check_got("t2_frame0", 0, '{w: 8'hC3, n: 4'd8, m: 1'b0});
    check_got("t2_frame1", 1, '{w: 8'h5A, n: 4'd8, m: 1'b0});

    // Short frame is left-aligned.
    got.delete();
    send_bits(16'h0006, 3, 1'b1);
    idle(3, 1'b1);
    check_got("t3_frame", 0, '{w: 8'hC0, n: 4'd3, m: 1'b0});

    // Stalled consumer: third frame dropped and flagged.
    send_bits(16'h0055, 7, 1'b0); idle(1, 1'b0);
    send_bits(16'h002A, 7, 1'b0); idle(1, 1'b0);
    send_bits(16'h0011, 7, 1'b0); idle(1, 1'b0);
    #1;
    check("t4_ovf_set", 32'(ovf_sticky), 32'd1);
    got.delete();
    idle(4, 1'b1);
    check("t4_xfers", 32'(got.size()), 32'd2);
    check_got("t4_frame0", 0, '{w: 8'hAA, n: 4'd7, m: 1'b1});
    check_got("t4_frame1", 1, '{w: 8'h54, n: 4'd7, m: 1'b0});
    step(1'b0, 1'b0, 1'b1, 1'b1);
    #1;
    check("t4_ovf_clr", 32'(ovf_sticky), 32'd0);

    // Asynchronous reset mid-frame discards the partial frame.
    send_bits(16'h0005, 4, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_zero_outputs("t5_async_reset");
    @(negedge clk);
    rst = 1'b0; ser_en = 1'b0;
    model_reset();
    got.delete();
    send_bits(16'h0055, 7, 1'b1);
    idle(3, 1'b1);
    check("t5_count", 32'(got.size()), 32'd1);
    check_got("t5_frame", 0, '{w: 8'hAA, n: 4'd7, m: 1'b1});

    // Full buffer with a pop on the same edge as a close: nothing dropped.
    send_bits(16'h000F, 7, 1'b0); idle(1, 1'b0);
    send_bits(16'h0070, 7, 1'b0); idle(1, 1'b0);
    send_bits(16'h0055, 7, 1'b0);
    got.delete();
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check("t6_no_ovf", 32'(ovf_sticky), 32'd0);
    idle(4, 1'b1);
    check("t6_count", 32'(got.size()), 32'd3);
    check_got("t6_frame0", 0, '{w: 8'h1E, n: 4'd7, m: 1'b0});
    check_got("t6_frame1", 1, '{w: 8'hE0, n: 4'd7, m: 1'b0});
    check_got("t6_frame2", 2, '{w: 8'hAA, n: 4'd7, m: 1'b1});

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 9) < 7), 1'($urandom), ($urandom_range(0, 9) < 5),
           ($urandom_range(0, 19) == 0));
    end
    idle(4, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
